camera_capture: RTL and testbench
=================================

# camera_capture

Captures one frame from an 8-bit DVP camera (OV7670-class, RGB565) into the camera frame-buffer RAM on request. It sits directly upstream of the AHB camera bridge. The bridge raises `DATA_VALID` when software writes the RAM-state register. This block then waits for the next frame start, packs pixel bytes into 32-bit words, and writes them sequentially from word 0. It pulses `DATA_READY` when the frame is complete, which clears the bridge's RAM-state bit. All camera pins are oversampled in the system clock domain.

## Interface
Parameters:
- `H_PIXELS`, 320: pixels per line.
- `V_LINES`, 240: lines per frame.
- `WORDS` (localparam), `H_PIXELS*V_LINES/2`: words per frame. Two RGB565 pixels per word. Must be ≤ 65536.

Ports (one clock; reset is asynchronous and active-low):
- `HCLK`  in  1: system clock. Must be ≥ 4× `CAM_PCLK`.
- `HRESETn`  in  1: asynchronous active-low reset.
- `CAM_PCLK`  in  1: camera pixel clock, treated as data.
- `CAM_VSYNC`  in  1: frame sync, active high.
- `CAM_HREF`  in  1: line valid, active high.
- `CAM_DATA`  in  8: pixel byte.
- `DATA_VALID`  in  1: capture request (bridge RAM-state bit), level.
- `DATA_READY`  out  1: one-cycle frame-done pulse.
- `WE`  out  1: RAM write enable.
- `WADDR`  out  16: RAM word address.
- `WDATA`  out  32: RAM write data.
- `BUSY`  out  1: high in all states other than IDLE.
- `SHORT_FRAME`  out  1: sticky. Last frame ended before `WORDS` words were written.

## Operation
- Synchronizer: a 2-flop sync on `CAM_PCLK`, `CAM_VSYNC`, `CAM_HREF`, and `CAM_DATA`. A third flop provides edge detection. A byte is accepted on a detected PCLK rising edge while synced HREF is high.
- FSM states:
  - IDLE: wait for `DATA_VALID`=1.
  - WAIT_VS: wait for a synced VSYNC falling edge. This is the frame start; a request raised mid-frame waits for the next frame.
  - CAPTURE: accept bytes.
  - DONE: assert `DATA_READY` for exactly one cycle, then return to IDLE.
- On entry to CAPTURE, the byte counter, `WADDR`, and `SHORT_FRAME` are cleared.
- Byte packing, per word:
  - byte0 → `WDATA[15:8]`
  - byte1 → `[7:0]`
  - byte2 → `[31:24]`
  - byte3 → `[23:16]`
  - Net effect: pixel 0 occupies the low halfword.
- `WE` pulses once per completed word. After each write, `WADDR` increments by 1.
- CAPTURE → DONE when either:
  - the write to address `WORDS-1` completes, or
  - a synced VSYNC rising edge is seen. In this case `SHORT_FRAME`=1 if fewer than `WORDS` words were written, and a partial word is discarded.
- Bytes beyond `WORDS` words are never written. `WADDR` never wraps.
- `DATA_VALID` dropping during WAIT_VS or CAPTURE is ignored; the frame completes.
- In DONE, `DATA_VALID` is ignored. IDLE re-arms only after the bridge's clear, so one request yields one frame.
- HREF falling mid-word keeps the partial byte count; packing continues on the next line. Line length × 2 bytes is always even.

## Timing
- Reset values:
  - `DATA_READY`=0, `WE`=0, `WADDR`=0, `WDATA`=0, `BUSY`=0, `SHORT_FRAME`=0.
  - FSM=IDLE, synchronizer flops=0.
- Pin-to-accept latency is fixed. A PCLK rise first sampled at HCLK edge n is accepted at edge n+3. For the 4th byte, `WE`, `WADDR`, and `WDATA` are registered and valid during the cycle following edge n+3. `WE` is high for exactly 1 cycle.
- `DATA_READY` is high during the cycle after the last `WE`, or 1 cycle after VSYNC-rise detection. The FSM is in IDLE the following cycle.
- `BUSY` rises 1 cycle after `DATA_VALID` is sampled high in IDLE.
- Reset mid-capture aborts immediately. No `DATA_READY` is issued. RAM contents are undefined.

## Structure
- `camera_pkg`: FSM state encoding, byte-lane index constants, and the `WADDR` width constant.
- Sub-module `cam_sync`: the parameterised-width 2-flop synchronizer with rising- and falling-edge outputs. It is instantiated once for the control bits and once for the data byte.

## Test plan
All scenarios use `H_PIXELS`=4 and `V_LINES`=2, so `WORDS`=4.
- Full frame:
  - Stimulus: request, VSYNC pulse, 2 lines of bytes 0x01..0x10.
  - Required: 4 `WE` pulses at addresses 0..3 with `WDATA` 0x03040102, 0x07080506, 0x0B0C090A, 0x0F100D0E. Then one `DATA_READY` pulse, and `SHORT_FRAME`=0.
- No request: 3 full frames → `WE` and `DATA_READY` never assert; `BUSY`=0.
- Request mid-frame: `DATA_VALID` raised during line 1 → no writes until after the next VSYNC fall; then the full-frame result above.
- Short frame: VSYNC rises after 9 bytes → 2 writes (addresses 0, 1) and `DATA_READY` pulse. `SHORT_FRAME`=1. The 9th byte is discarded.
- Overflow: 20 bytes in a frame → exactly 4 writes, `WADDR` never exceeds 3, and `DATA_READY` pulses after the 4th write.
- Reset mid-capture: assert `HRESETn` after 1 word → all outputs at reset values, no `DATA_READY`. A fresh request then captures correctly.

Source files
------------

// File: rtl/camera_pkg.sv
// Shared types and constants for the DVP camera capture block.
// Byte-lane constants place each RGB565 pixel's high byte first, pixel 0 in the low halfword.
package camera_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    localparam int CTL_PCLK  = 0;
    localparam int CTL_HREF  = 1;
    localparam int CTL_VSYNC = 2;
    localparam int CTL_W     = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_e;

    localparam logic [1:0] LANE_BYTE0 = 2'd1;
    localparam logic [1:0] LANE_BYTE1 = 2'd0;
    localparam logic [1:0] LANE_BYTE2 = 2'd3;
    localparam logic [1:0] LANE_BYTE3 = 2'd2;

    function automatic logic [1:0] byte_lane(input logic [1:0] idx);
        logic [1:0] lane;
        unique case (idx)
            2'd0:    lane = LANE_BYTE0;
            2'd1:    lane = LANE_BYTE1;
            2'd2:    lane = LANE_BYTE2;
            default: lane = LANE_BYTE3;
        endcase
        return lane;
    endfunction

endpackage

// File: rtl/cam_sync.sv
// Two-flop synchronizer plus history flop; edge pulses are registered so that
// dout and the rise/fall pulses refer to the same sampled value.
module cam_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0] hist_q, hist_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;

    always_comb begin
        meta_d = din;
        sync_d = meta_q;
        hist_d = sync_q;
        rise_d = sync_q & ~hist_q;
        fall_d = ~sync_q & hist_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
            hist_q <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            hist_q <= hist_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign dout = hist_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/camera_capture.sv
// Captures one DVP RGB565 frame per request into the frame-buffer RAM as packed 32-bit words.
// State table:  IDLE | wait for request ; WAIT_VS | wait frame start ; CAPTURE | pack/write ; DONE | frame-done pulse
module camera_capture
    import camera_pkg::*;
#(
    parameter int H_PIXELS = 320,
    parameter int V_LINES  = 240
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              CAM_PCLK,
    input  logic              CAM_VSYNC,
    input  logic              CAM_HREF,
    input  logic [7:0]        CAM_DATA,
    input  logic              DATA_VALID,
    output logic              DATA_READY,
    output logic              WE,
    output logic [ADDR_W-1:0] WADDR,
    output logic [DATA_W-1:0] WDATA,
    output logic              BUSY,
    output logic              SHORT_FRAME
);

    localparam int WORDS = H_PIXELS * V_LINES / 2;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

    logic [CTL_W-1:0] ctl_s, ctl_rise, ctl_fall;
    logic [7:0]       data_s, data_rise_unused, data_fall_unused;
    logic             ctl_unused;

    cam_sync #(.WIDTH(CTL_W)) u_ctl_sync (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .din   ({CAM_VSYNC, CAM_HREF, CAM_PCLK}),
        .dout  (ctl_s),
        .rise  (ctl_rise),
        .fall  (ctl_fall)
    );

    cam_sync #(.WIDTH(8)) u_data_sync (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .din   (CAM_DATA),
        .dout  (data_s),
        .rise  (data_rise_unused),
        .fall  (data_fall_unused)
    );

    logic byte_accept, vs_rise, vs_fall;

    assign byte_accept = ctl_rise[CTL_PCLK] & ctl_s[CTL_HREF];
    assign vs_rise     = ctl_rise[CTL_VSYNC];
    assign vs_fall     = ctl_fall[CTL_VSYNC];
    assign ctl_unused  = ^{ctl_s[CTL_PCLK], ctl_s[CTL_VSYNC], ctl_rise[CTL_HREF],
                           ctl_fall[CTL_PCLK], ctl_fall[CTL_HREF]};

    cap_state_e        state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [DATA_W-1:0] pack_q, pack_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              ready_q, ready_d;
    logic              short_q, short_d;
    logic [4:0]        lane_lsb;

    assign lane_lsb = {byte_lane(byte_cnt_q), 3'b000};

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        pack_d     = pack_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        ready_d    = 1'b0;
        short_d    = short_q;

        unique case (state_q)
            ST_IDLE: begin
                if (DATA_VALID) begin
                    state_d = ST_WAIT_VS;
                end
            end
            ST_WAIT_VS: begin
                if (vs_fall) begin
                    state_d    = ST_CAPTURE;
                    byte_cnt_d = 2'd0;
                    waddr_d    = '0;
                    short_d    = 1'b0;
                end
            end
            ST_CAPTURE: begin
                // A completed final write wins over a coincident VSYNC rise.
                if (we_q && (waddr_q == LAST_ADDR)) begin
                    state_d = ST_DONE;
                    ready_d = 1'b1;
                end else if (vs_rise) begin
                    state_d = ST_DONE;
                    ready_d = 1'b1;
                    short_d = 1'b1;
                end else begin
                    if (we_q) begin
                        waddr_d = waddr_q + 1'b1;
                    end
                    if (byte_accept) begin
                        pack_d[lane_lsb +: 8] = data_s;
                        byte_cnt_d            = byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            we_d    = 1'b1;
                            wdata_d = pack_d;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= ST_IDLE;
            byte_cnt_q <= 2'd0;
            pack_q     <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            ready_q    <= 1'b0;
            short_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            pack_q     <= pack_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            ready_q    <= ready_d;
            short_q    <= short_d;
        end
    end

    assign DATA_READY  = ready_q;
    assign WE          = we_q;
    assign WADDR       = waddr_q;
    assign WDATA       = wdata_q;
    assign BUSY        = (state_q != ST_IDLE);
    assign SHORT_FRAME = short_q;

endmodule

// File: tb/tb_camera_capture.sv
// Directed bench for camera_capture with a 4x2 frame (4 words per frame).
module tb_camera_capture;

    logic        HCLK;
    logic        HRESETn;
    logic        CAM_PCLK;
    logic        CAM_VSYNC;
    logic        CAM_HREF;
    logic [7:0]  CAM_DATA;
    logic        DATA_VALID;
    logic        DATA_READY;
    logic        WE;
    logic [15:0] WADDR;
    logic [31:0] WDATA;
    logic        BUSY;
    logic        SHORT_FRAME;

    camera_capture #(.H_PIXELS(4), .V_LINES(2)) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .CAM_PCLK    (CAM_PCLK),
        .CAM_VSYNC   (CAM_VSYNC),
        .CAM_HREF    (CAM_HREF),
        .CAM_DATA    (CAM_DATA),
        .DATA_VALID  (DATA_VALID),
        .DATA_READY  (DATA_READY),
        .WE          (WE),
        .WADDR       (WADDR),
        .WDATA       (WDATA),
        .BUSY        (BUSY),
        .SHORT_FRAME (SHORT_FRAME)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    int          n_checks = 0;
    int          n_errors = 0;
    int          we_cnt, dr_cnt, rise_cnt;
    logic [15:0] max_waddr;
    logic        busy_seen;
    logic [15:0] we_addr [0:31];
    logic [31:0] we_data [0:31];
    longint      we_time [0:31];
    longint      rise_time [0:63];
    longint      dr_time;
    logic [31:0] exp_word [0:3];

    // Bus monitor plus bridge model: DATA_READY clears the request bit.
    always @(negedge HCLK) begin
        if (WE) begin
            if (we_cnt < 32) begin
                we_addr[we_cnt] = WADDR;
                we_data[we_cnt] = WDATA;
                we_time[we_cnt] = $time;
            end
            if (WADDR > max_waddr) max_waddr = WADDR;
            we_cnt++;
        end
        if (DATA_READY) begin
            dr_time    = $time;
            dr_cnt++;
            DATA_VALID = 1'b0;
        end
        if (BUSY) busy_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        we_cnt    = 0;
        dr_cnt    = 0;
        rise_cnt  = 0;
        max_waddr = '0;
        busy_seen = 1'b0;
        dr_time   = 0;
    endtask

    task automatic pclk_byte(input logic [7:0] b);
        @(negedge HCLK);
        CAM_DATA = b;
        CAM_HREF = 1'b1;
        CAM_PCLK = 1'b0;
        repeat (4) @(negedge HCLK);
        CAM_PCLK = 1'b1;
        rise_time[rise_cnt % 64] = $time;
        rise_cnt++;
        repeat (3) @(negedge HCLK);
    endtask

    task automatic send_bytes(input int first, input int n);
        for (int i = 0; i < n; i++) pclk_byte(8'(first + i));
    endtask

    task automatic line_end();
        @(negedge HCLK);
        CAM_HREF = 1'b0;
        CAM_PCLK = 1'b0;
        repeat (8) @(negedge HCLK);
    endtask

    task automatic vsync_pulse();
        @(negedge HCLK);
        CAM_VSYNC = 1'b1;
        repeat (12) @(negedge HCLK);
        CAM_VSYNC = 1'b0;
        repeat (12) @(negedge HCLK);
    endtask

    task automatic full_frame_bytes();
        send_bytes(1, 8);
        line_end();
        send_bytes(9, 8);
        line_end();
        repeat (10) @(negedge HCLK);
    endtask

    task automatic check_frame(input string tag);
        check({tag, "_we_count"}, we_cnt, 32'd4);
        for (int i = 0; i < 4; i++) begin
            check({tag, "_addr"}, we_addr[i], 32'(i));
            check({tag, "_data"}, we_data[i], exp_word[i]);
        end
        check({tag, "_ready_count"}, dr_cnt, 32'd1);
        check({tag, "_short"}, SHORT_FRAME, 32'd0);
        check({tag, "_busy_end"}, BUSY, 32'd0);
        check({tag, "_max_addr"}, max_waddr, 32'd3);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, DATA_READY, 32'd0);
        check({tag, "_we"}, WE, 32'd0);
        check({tag, "_waddr"}, WADDR, 32'd0);
        check({tag, "_wdata"}, WDATA, 32'd0);
        check({tag, "_busy"}, BUSY, 32'd0);
        check({tag, "_short"}, SHORT_FRAME, 32'd0);
    endtask

    initial begin
        exp_word[0] = 32'h03040102;
        exp_word[1] = 32'h07080506;
        exp_word[2] = 32'h0B0C090A;
        exp_word[3] = 32'h0F100D0E;
        HRESETn    = 1'b0;
        CAM_PCLK   = 1'b0;
        CAM_VSYNC  = 1'b0;
        CAM_HREF   = 1'b0;
        CAM_DATA   = 8'h00;
        DATA_VALID = 1'b0;
        clear_log();
        repeat (3) @(negedge HCLK);
        check_reset_outputs("reset");
        HRESETn = 1'b1;
        repeat (3) @(negedge HCLK);

        // No request: three frames pass untouched
        clear_log();
        for (int f = 0; f < 3; f++) begin
            vsync_pulse();
            full_frame_bytes();
        end
        check("noreq_we", we_cnt, 32'd0);
        check("noreq_ready", dr_cnt, 32'd0);
        check("noreq_busy", busy_seen, 32'd0);

        // Full frame with latency checks
        clear_log();
        @(negedge HCLK);
        DATA_VALID = 1'b1;
        @(negedge HCLK);
        @(negedge HCLK);
        check("full_busy_rise", BUSY, 32'd1);
        vsync_pulse();
        full_frame_bytes();
        check_frame("full");
        check("full_we_latency", 32'(we_time[0] - rise_time[3]), 32'd40);
        check("full_ready_latency", 32'(dr_time - we_time[3]), 32'd10);
        check("full_req_cleared", DATA_VALID, 32'd0);

        // Request raised mid-frame waits for the next frame start
        clear_log();
        vsync_pulse();
        send_bytes(1, 3);
        DATA_VALID = 1'b1;
        send_bytes(4, 5);
        line_end();
        send_bytes(9, 8);
        line_end();
        check("mid_no_write", we_cnt, 32'd0);
        check("mid_waiting_busy", BUSY, 32'd1);
        vsync_pulse();
        full_frame_bytes();
        check_frame("mid");

        // Short frame: VSYNC rises after 9 bytes
        clear_log();
        DATA_VALID = 1'b1;
        vsync_pulse();
        send_bytes(1, 8);
        line_end();
        send_bytes(9, 1);
        @(negedge HCLK);
        CAM_HREF  = 1'b0;
        CAM_VSYNC = 1'b1;
        repeat (20) @(negedge HCLK);
        CAM_VSYNC = 1'b0;
        repeat (20) @(negedge HCLK);
        check("short_we_count", we_cnt, 32'd2);
        check("short_addr0", we_addr[0], 32'd0);
        check("short_data0", we_data[0], exp_word[0]);
        check("short_addr1", we_addr[1], 32'd1);
        check("short_data1", we_data[1], exp_word[1]);
        check("short_ready", dr_cnt, 32'd1);
        check("short_flag", SHORT_FRAME, 32'd1);
        check("short_busy", BUSY, 32'd0);

        // Overflow: 20 bytes, only 4 words written, short flag cleared
        clear_log();
        DATA_VALID = 1'b1;
        vsync_pulse();
        send_bytes(1, 10);
        line_end();
        send_bytes(11, 10);
        line_end();
        repeat (10) @(negedge HCLK);
        check_frame("ovf");

        // Reset mid-capture, then a fresh capture
        clear_log();
        DATA_VALID = 1'b1;
        vsync_pulse();
        send_bytes(1, 5);
        @(negedge HCLK);
        CAM_HREF = 1'b0;
        repeat (5) @(negedge HCLK);
        check("rst_one_word", we_cnt, 32'd1);
        check("rst_waddr_before", WADDR, 32'd1);
        HRESETn = 1'b0;
        @(negedge HCLK);
        check_reset_outputs("rst_mid");
        repeat (3) @(negedge HCLK);
        HRESETn = 1'b1;
        repeat (10) @(negedge HCLK);
        check("rst_no_ready", dr_cnt, 32'd0);
        clear_log();
        vsync_pulse();
        full_frame_bytes();
        check_frame("rst_fresh");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
